// File: rtl/ip_checksum_ttl_check.sv
`default_nettype none
// ============================================================================
// Module   : ip_checksum_ttl_check
// Purpose  : Samples the IPv4 header off the packet bus, checks its checksum,
//            classifies the packet, precomputes TTL-1 and the patched
//            checksum, and queues one result per packet for the port lookup.
// Revision : 1.0 - initial release
// ============================================================================
module ip_checksum_ttl_check #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH/8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_wr,
    input  logic                  word_ETH_IP_VER,
    input  logic                  word_IP_LEN_ID,
    input  logic                  word_IP_CHECKSUM_SRC_HI,
    input  logic                  word_IP_DST_LO,
    input  logic                  rd_ip_checks,
    output logic                  ip_checks_vld,
    output logic                  is_ip_pkt,
    output logic                  ip_hdr_has_options,
    output logic                  ip_checksum_ok,
    output logic                  ip_ttl_expired,
    output logic [7:0]            ip_new_ttl,
    output logic [15:0]           ip_new_checksum,
    output logic                  ip_checks_ovfl
);

    generate
        if (DATA_WIDTH != 64 || CTRL_WIDTH != DATA_WIDTH/8 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("ip_checksum_ttl_check: unsupported parameter set");
        end
    endgenerate

    localparam int            c_AW      = $clog2(FIFO_DEPTH);
    localparam int            c_ENTRY_W = 28;
    localparam logic [c_AW:0] c_FULL    = (c_AW+1)'(FIFO_DEPTH);

    function automatic logic [19:0] hw_sum(input logic [63:0] d);
        hw_sum = {4'h0, d[63:48]} + {4'h0, d[47:32]} + {4'h0, d[31:16]} + {4'h0, d[15:0]};
    endfunction

    // ------------------------------------------------------------------
    // Header capture and checksum accumulation
    // ------------------------------------------------------------------
    logic        w_eth, w_len, w_src, w_dst;
    logic [19:0] sum_q, sum_d;
    logic [15:0] ethertype_q, ethertype_d;
    logic [7:0]  ver_ihl_q, ver_ihl_d;
    logic [7:0]  ttl_q, ttl_d;
    logic [15:0] csum_q, csum_d;
    logic        in_pkt_q, in_pkt_d;
    logic        v0_q, v0_d;

    assign w_eth = word_ETH_IP_VER         & in_wr;
    assign w_len = word_IP_LEN_ID          & in_wr;
    assign w_src = word_IP_CHECKSUM_SRC_HI & in_wr;
    assign w_dst = word_IP_DST_LO          & in_wr;

    always_comb begin
        sum_d       = sum_q;
        ethertype_d = ethertype_q;
        ver_ihl_d   = ver_ihl_q;
        ttl_d       = ttl_q;
        csum_d      = csum_q;
        in_pkt_d    = in_pkt_q;
        v0_d        = 1'b0;
        if (w_eth) begin
            sum_d       = {4'h0, in_data[15:0]};
            ethertype_d = in_data[31:16];
            ver_ihl_d   = in_data[15:8];
            in_pkt_d    = 1'b1;
        end
        if (w_len) begin
            sum_d = sum_q + hw_sum(in_data[63:0]);
            ttl_d = in_data[15:8];
        end
        if (w_src) begin
            sum_d  = sum_q + hw_sum(in_data[63:0]);
            csum_d = in_data[63:48];
        end
        // A DST_LO without a preceding ETH_IP_VER (e.g. after reset) yields nothing
        if (w_dst) begin
            sum_d    = sum_q + {4'h0, in_data[63:48]};
            v0_d     = in_pkt_q;
            in_pkt_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q       <= '0;
            ethertype_q <= '0;
            ver_ihl_q   <= '0;
            ttl_q       <= '0;
            csum_q      <= '0;
            in_pkt_q    <= 1'b0;
            v0_q        <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            ethertype_q <= ethertype_d;
            ver_ihl_q   <= ver_ihl_d;
            ttl_q       <= ttl_d;
            csum_q      <= csum_d;
            in_pkt_q    <= in_pkt_d;
            v0_q        <= v0_d;
        end
    end

    // ------------------------------------------------------------------
    // Fold stage 1: snapshot the header fields so the next packet may start
    // ------------------------------------------------------------------
    logic [16:0] s1_q, s1_d;
    logic [16:0] w_tcsum;
    logic        is_ip_q, is_ip_d;
    logic        opts_q, opts_d;
    logic        expired_q, expired_d;
    logic [7:0]  new_ttl_q, new_ttl_d;
    logic [15:0] new_csum_q, new_csum_d;
    logic        v1_q;

    always_comb begin
        s1_d       = {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
        // RFC1624 incremental update: TTL is the high byte, so TTL-1 adds 0x0100
        w_tcsum    = {1'b0, csum_q} + 17'h00100;
        new_csum_d = w_tcsum[15:0] + {15'h0, w_tcsum[16]};
        is_ip_d    = (ethertype_q == 16'h0800) && (ver_ihl_q[7:4] == 4'h4);
        opts_d     = (ver_ihl_q[3:0] != 4'h5);
        expired_d  = (ttl_q <= 8'd1);
        new_ttl_d  = (ttl_q == 8'h00) ? 8'h00 : ttl_q - 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q       <= 1'b0;
            s1_q       <= '0;
            is_ip_q    <= 1'b0;
            opts_q     <= 1'b0;
            expired_q  <= 1'b0;
            new_ttl_q  <= '0;
            new_csum_q <= '0;
        end else begin
            v1_q <= v0_q;
            if (v0_q) begin
                s1_q       <= s1_d;
                is_ip_q    <= is_ip_d;
                opts_q     <= opts_d;
                expired_q  <= expired_d;
                new_ttl_q  <= new_ttl_d;
                new_csum_q <= new_csum_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fold stage 2 and result entry
    // ------------------------------------------------------------------
    logic [15:0]          w_s2;
    logic                 w_csum_ok;
    logic [c_ENTRY_W-1:0] w_entry;

    assign w_s2      = s1_q[15:0] + {15'h0, s1_q[16]};
    assign w_csum_ok = (w_s2 == 16'hFFFF) && !opts_q;
    assign w_entry   = {is_ip_q, opts_q, w_csum_ok, expired_q, new_ttl_q, new_csum_q};

    // ------------------------------------------------------------------
    // Show-ahead result FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [c_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]        count_q, count_d;
    logic                 ovfl_q, ovfl_d;
    logic                 w_full, w_empty, w_pop, w_push;
    logic [c_ENTRY_W-1:0] w_head;

    assign w_full  = (count_q == c_FULL);
    assign w_empty = (count_q == '0);
    assign w_pop   = rd_ip_checks && !w_empty;
    // When full, a same-cycle pop frees the slot the push needs
    assign w_push  = v1_q && (!w_full || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovfl_d   = v1_q && w_full && !w_pop;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_AW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_AW'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + (c_AW+1)'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - (c_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovfl_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovfl_q   <= ovfl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    // Storage is not reset, so the head is masked while the FIFO is empty
    assign w_head = w_empty ? '0 : mem_q[rd_ptr_q];

    assign ip_checks_vld      = !w_empty;
    assign is_ip_pkt          = w_head[27];
    assign ip_hdr_has_options = w_head[26];
    assign ip_checksum_ok     = w_head[25];
    assign ip_ttl_expired     = w_head[24];
    assign ip_new_ttl         = w_head[23:16];
    assign ip_new_checksum    = w_head[15:0];
    assign ip_checks_ovfl     = ovfl_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_checksum_ttl_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_checksum_ttl_check
// Purpose  : Self-checking bench for ip_checksum_ttl_check against a
//            packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_checksum_ttl_check;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] in_data = '0;
    logic        in_wr = 1'b0;
    logic        s_eth = 1'b0, s_len = 1'b0, s_src = 1'b0, s_dst = 1'b0;
    logic        rd = 1'b0;
    logic        vld, is_ip, opts, ok, expired, ovfl;
    logic [7:0]  new_ttl;
    logic [15:0] new_csum;

    ip_checksum_ttl_check #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .in_data                 (in_data),
        .in_wr                   (in_wr),
        .word_ETH_IP_VER         (s_eth),
        .word_IP_LEN_ID          (s_len),
        .word_IP_CHECKSUM_SRC_HI (s_src),
        .word_IP_DST_LO          (s_dst),
        .rd_ip_checks            (rd),
        .ip_checks_vld           (vld),
        .is_ip_pkt               (is_ip),
        .ip_hdr_has_options      (opts),
        .ip_checksum_ok          (ok),
        .ip_ttl_expired          (expired),
        .ip_new_ttl              (new_ttl),
        .ip_new_checksum         (new_csum),
        .ip_checks_ovfl          (ovfl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_ip;
        logic        opts;
        logic        ok;
        logic        exp;
        logic [7:0]  ttl;
        logic [15:0] csum;
    } res_t;

    typedef struct packed {
        logic [15:0] eth;
        logic [7:0]  vi;
        logic [7:0]  tos;
        logic [15:0] len;
        logic [15:0] id;
        logic [15:0] frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] csum;
        logic [31:0] src;
        logic [31:0] dst;
    } pkt_t;

    typedef struct {
        int   due;
        res_t r;
    } pend_t;

    res_t dut_res;
    assign dut_res = {is_ip, opts, ok, expired, new_ttl, new_csum};

    int   checks = 0;
    int   errors = 0;
    int   ovfl_pulses = 0;
    bit   chk_en = 1'b0;
    bit   rand_rd = 1'b0;

    // ---------------- reference model ----------------
    function automatic int unsigned fold(input int unsigned s_in);
        int unsigned s;
        s = s_in;
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s;
    endfunction

    function automatic int unsigned hdr_sum(input pkt_t p, input bit with_csum);
        int unsigned s;
        s = {p.vi, p.tos} + p.len + p.id + p.frag + {p.ttl, p.proto}
            + p.src[31:16] + p.src[15:0] + p.dst[31:16] + p.dst[15:0];
        if (with_csum) s = s + p.csum;
        return s;
    endfunction

    function automatic res_t expect_of(input pkt_t p);
        res_t        r;
        int unsigned c;
        r.is_ip = (p.eth == 16'h0800) && (p.vi[7:4] == 4'h4);
        r.opts  = (p.vi[3:0] != 4'h5);
        r.ok    = (fold(hdr_sum(p, 1'b1)) == 32'hFFFF) && !r.opts;
        r.exp   = (p.ttl < 8'd2);
        r.ttl   = (p.ttl == 8'h00) ? 8'h00 : p.ttl - 8'd1;
        c = p.csum + 32'd256;
        if (c > 32'hFFFF) c = c - 32'hFFFF;
        r.csum = c[15:0];
        return r;
    endfunction

    res_t  mq[$];
    pend_t pend[$];
    bit    exp_ovfl = 1'b0;

    initial begin : model
        int    edge_n;
        bit    in_pkt;
        bit    do_pop;
        pkt_t  cur;
        pend_t pe;
        edge_n = 0;
        in_pkt = 1'b0;
        cur    = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (reset) begin
                mq.delete();
                pend.delete();
                in_pkt   = 1'b0;
                exp_ovfl = 1'b0;
            end else begin
                do_pop   = rd && (mq.size() > 0);
                exp_ovfl = 1'b0;
                if (do_pop) void'(mq.pop_front());
                if (pend.size() > 0 && pend[0].due == edge_n) begin
                    pe = pend.pop_front();
                    if (mq.size() < DEPTH) mq.push_back(pe.r);
                    else exp_ovfl = 1'b1;
                end
                if (in_wr && s_eth) begin
                    cur.eth = in_data[31:16]; cur.vi = in_data[15:8]; cur.tos = in_data[7:0];
                    in_pkt = 1'b1;
                end
                if (in_wr && s_len) begin
                    {cur.len, cur.id, cur.frag, cur.ttl, cur.proto} = in_data;
                end
                if (in_wr && s_src) begin
                    cur.csum = in_data[63:48]; cur.src = in_data[47:16]; cur.dst[31:16] = in_data[15:0];
                end
                if (in_wr && s_dst) begin
                    cur.dst[15:0] = in_data[63:48];
                    if (in_pkt) begin
                        pe.due = edge_n + 2;
                        pe.r   = expect_of(cur);
                        pend.push_back(pe);
                    end
                    in_pkt = 1'b0;
                end
            end
        end
    end

    // ---------------- comparison helpers ----------------
    task automatic chk1(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_res(input string nm, input res_t act, input res_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got ip=%0b opt=%0b ok=%0b exp=%0b ttl=%h csum=%h expected ip=%0b opt=%0b ok=%0b exp=%0b ttl=%h csum=%h at %0t",
                     nm, act.is_ip, act.opts, act.ok, act.exp, act.ttl, act.csum,
                     req.is_ip, req.opts, req.ok, req.exp, req.ttl, req.csum, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    initial begin : compare
        res_t head;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("vld", vld, mq.size() != 0);
                chk1("ovfl", ovfl, exp_ovfl);
                head = '0;
                if (mq.size() != 0) head = mq[0];
                chk_res("head", dut_res, head);
                if (ovfl === 1'b1) ovfl_pulses++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int which, input logic [63:0] d);
        @(negedge clk);
        in_data = d;
        in_wr   = 1'b1;
        s_eth   = (which == 0);
        s_len   = (which == 1);
        s_src   = (which == 2);
        s_dst   = (which == 3);
        if (rand_rd) rd = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_wr = 1'b0; s_eth = 1'b0; s_len = 1'b0; s_src = 1'b0; s_dst = 1'b0;
            in_data = {$urandom, $urandom};
            if (rand_rd) rd = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_pkt(input pkt_t p);
        drive(0, {$urandom, p.eth, p.vi, p.tos});
        drive(1, {p.len, p.id, p.frag, p.ttl, p.proto});
        drive(2, {p.csum, p.src, p.dst[31:16]});
        drive(3, {p.dst[15:0], 16'($urandom), $urandom});
    endtask

    task automatic pop1();
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (vld) begin
                rd = 1'b1;
                n++;
            end else begin
                break;
            end
        end
        rd = 1'b0;
    endtask

    // Sends one packet and checks its result appears exactly in T+3
    task automatic run_one(input string nm, input pkt_t p, input res_t e, input bit only_ip);
        send_pkt(p);
        idle(2);
        chk1({nm, "_early"}, vld, 1'b0);
        idle(1);
        chk1({nm, "_vld"}, vld, 1'b1);
        if (only_ip) chk1({nm, "_is_ip"}, is_ip, e.is_ip);
        else         chk_res(nm, dut_res, e);
        pop1();
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t        p;
        logic [7:0]  vis [5];
        int unsigned r;
        vis = '{8'h46, 8'h44, 8'h55, 8'h4F, 8'h65};
        p.eth   = ($urandom_range(0, 4) == 0) ? 16'h0806 : 16'h0800;
        p.vi    = ($urandom_range(0, 4) != 0) ? 8'h45 : vis[$urandom_range(0, 4)];
        p.tos   = 8'($urandom);
        p.len   = 16'($urandom);
        p.id    = 16'($urandom);
        p.frag  = 16'($urandom);
        r       = $urandom_range(0, 5);
        p.ttl   = (r < 3) ? 8'(r) : 8'($urandom);
        p.proto = 8'($urandom);
        p.src   = $urandom;
        p.dst   = $urandom;
        p.csum  = ~16'(fold(hdr_sum(p, 1'b0)));
        if ($urandom_range(0, 3) == 0) p.csum = 16'($urandom);
        if ($urandom_range(0, 15) == 0) p.csum = 16'hFF00 + 16'($urandom_range(0, 255));
        return p;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        pkt_t p1, p;
        int   n, base;

        p1 = '{eth:16'h0800, vi:8'h45, tos:8'h00, len:16'h0073, id:16'h0000, frag:16'h4000,
               ttl:8'h40, proto:8'h11, csum:16'hB861, src:32'hC0A80001, dst:32'hC0A800C7};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk1("reset_vld", vld, 1'b0);
        chk_res("reset_head", dut_res, res_t'(28'h0));
        chk1("reset_ovfl", ovfl, 1'b0);

        // Known-good header and the model agreeing with hand-computed values
        chk_res("model_pin1", expect_of(p1), res_t'({4'b1010, 8'h3F, 16'hB961}));
        run_one("case1", p1, res_t'({4'b1010, 8'h3F, 16'hB961}), 1'b0);
        p = p1; p.csum = 16'hB862;
        run_one("bad_csum", p, res_t'({4'b1000, 8'h3F, 16'hB962}), 1'b0);
        p = p1; p.ttl = 8'h01;
        run_one("ttl1", p, res_t'({4'b1001, 8'h00, 16'hB961}), 1'b0);
        p = p1; p.ttl = 8'h00;
        chk_res("model_pin_ttl0", expect_of(p), res_t'({4'b1001, 8'h00, 16'hB961}));
        run_one("ttl0", p, res_t'({4'b1001, 8'h00, 16'hB961}), 1'b0);
        p = p1; p.csum = 16'hFF00;
        chk_res("model_pin_wrap", expect_of(p), res_t'({4'b1000, 8'h3F, 16'h0001}));
        run_one("csum_wrap", p, res_t'({4'b1000, 8'h3F, 16'h0001}), 1'b0);
        p = p1; p.eth = 16'h0806;
        run_one("arp", p, res_t'({4'b0000, 8'h3F, 16'hB961}), 1'b1);
        p = p1; p.vi = 8'h46;
        run_one("opts", p, res_t'({4'b1100, 8'h3F, 16'hB961}), 1'b0);

        // Overflow: five packets without popping, then push+pop while full
        base = ovfl_pulses;
        for (int i = 0; i < 5; i++) begin
            p = p1; p.ttl = 8'h11 + 8'(i);
            send_pkt(p);
        end
        idle(5);
        chk_int("ovfl_pulses", ovfl_pulses - base, 1);
        chk1("full_vld", vld, 1'b1);
        p = p1; p.ttl = 8'h16;
        send_pkt(p);
        idle(2);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk_int("no_ovfl_on_pushpop", ovfl_pulses - base, 1);
        chk_int("head_after_pushpop", int'(new_ttl), 8'h11);
        drain(n);
        chk_int("drain_count", n, 4);

        // Back-to-back packets
        send_pkt(p1);
        p = p1; p.csum = 16'hB862;
        send_pkt(p);
        idle(5);
        chk_res("b2b_first", dut_res, res_t'({4'b1010, 8'h3F, 16'hB961}));
        pop1();
        chk_res("b2b_second", dut_res, res_t'({4'b1000, 8'h3F, 16'hB962}));
        pop1();
        chk1("b2b_empty", vld, 1'b0);

        // Reset in the middle of a packet
        drive(0, {32'h0, p1.eth, p1.vi, p1.tos});
        drive(1, {p1.len, p1.id, p1.frag, p1.ttl, p1.proto});
        idle(1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(2, {p1.csum, p1.src, p1.dst[31:16]});
        drive(3, {p1.dst[15:0], 48'h0});
        idle(6);
        chk1("mid_reset_no_push", vld, 1'b0);
        run_one("after_reset", p1, res_t'({4'b1010, 8'h3F, 16'hB961}), 1'b0);

        // Randomized traffic with random pops
        rand_rd = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send_pkt(rand_pkt());
            idle($urandom_range(0, 2));
        end
        rand_rd = 1'b0;
        idle(4);
        drain(n);
        idle(2);
        chk1("final_empty", vld, 1'b0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
